// File: rtl/hazard_stall_ctl.sv
// Pipeline hazard/stall sequencer: load-use bubbles, multi-cycle MEM waits,
// taken-branch squash, and a saturating stall-cycle counter.
module hazard_stall_ctl #(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned LOAD_BUBBLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_src_a,
  input  logic [REG_ADDR_W-1:0] id_src_b,
  input  logic                  id_uses_a,
  input  logic                  id_uses_b,
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic                  mem_multi,
  input  logic                  mem_ready,
  input  logic                  branch_taken,
  output logic                  pc_hold,
  output logic                  if_id_hold,
  output logic                  if_id_flush,
  output logic                  id_ex_stall,
  output logic                  id_ex_hold,
  output logic                  mem_freeze,
  output logic                  timeout_err,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int unsigned BCNT_W    = 4;
  localparam int unsigned TCNT_W    = 8;
  localparam int unsigned BCNT_INIT = (LOAD_BUBBLES >= 2) ? (LOAD_BUBBLES - 2) : 0;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  state_t            cur_state, nxt_state;
  logic [BCNT_W-1:0] bcnt, bcnt_nxt;
  logic [TCNT_W-1:0] tcnt, tcnt_nxt;
  logic              terr_set;
  logic              hazard;

  // Load-use hazard; register 0 is hard-wired and never conflicts
  assign hazard = ex_valid & ex_is_load & (ex_dst != '0) &
                  ((id_uses_a & (id_src_a == ex_dst)) |
                   (id_uses_b & (id_src_b == ex_dst)));

  assign state = cur_state;

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state    <= RUN;
      bcnt         <= '0;
      tcnt         <= '0;
      timeout_err  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      cur_state <= nxt_state;
      bcnt      <= bcnt_nxt;
      tcnt      <= tcnt_nxt;
      if (terr_set) timeout_err <= 1'b1;
      if (pc_hold && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  always_comb begin
    nxt_state   = cur_state;
    bcnt_nxt    = bcnt;
    tcnt_nxt    = tcnt;
    terr_set    = 1'b0;
    pc_hold     = 1'b0;
    if_id_hold  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_stall = 1'b0;
    id_ex_hold  = 1'b0;
    mem_freeze  = 1'b0;

    if (reset) begin
      // Squash everything while reset is held
      id_ex_stall = 1'b1;
      if_id_flush = 1'b1;
      nxt_state   = RUN;
    end else begin
      unique case (cur_state)
        RUN: begin
          if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_stall = 1'b1;
          end else if (mem_multi) begin
            pc_hold    = 1'b1;
            if_id_hold = 1'b1;
            id_ex_hold = 1'b1;
            mem_freeze = 1'b1;
            tcnt_nxt   = '0;
            nxt_state  = MEM_WAIT;
          end else if (hazard) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_stall = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              bcnt_nxt  = BCNT_W'(BCNT_INIT);
              nxt_state = LOAD_STALL;
            end
          end
        end

        LOAD_STALL: begin
          if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_stall = 1'b1;
            nxt_state   = RUN;
          end else begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_stall = 1'b1;
            if (bcnt != '0) bcnt_nxt = bcnt - BCNT_W'(1);
            else            nxt_state = RUN;
          end
        end

        MEM_WAIT: begin
          // EX is frozen here, so a branch indication cannot be acted on
          if (mem_ready) begin
            nxt_state = RUN;
          end else begin
            pc_hold    = 1'b1;
            if_id_hold = 1'b1;
            id_ex_hold = 1'b1;
            mem_freeze = 1'b1;
            if (tcnt == TCNT_W'(MEM_TIMEOUT - 1)) begin
              terr_set  = 1'b1;
              nxt_state = RUN;
            end else begin
              tcnt_nxt = tcnt + TCNT_W'(1);
            end
          end
        end

        default: nxt_state = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctl.sv
// Self-checking bench for hazard_stall_ctl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_hazard_stall_ctl;

  localparam int unsigned RW  = 5;
  localparam int unsigned LB  = 2;
  localparam int unsigned MT  = 15;
  localparam int unsigned CW  = 5;
  localparam int unsigned SAT = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [RW-1:0] id_src_a, id_src_b, ex_dst;
  logic          id_uses_a, id_uses_b, ex_valid, ex_is_load;
  logic          mem_multi, mem_ready, branch_taken;
  logic          pc_hold, if_id_hold, if_id_flush, id_ex_stall, id_ex_hold, mem_freeze;
  logic          timeout_err;
  logic [1:0]    state;
  logic [CW-1:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 run, 1 extra bubbles pending, 2 waiting on memory
  int m_mode   = 0;
  int m_left   = 0;
  int m_waited = 0;
  int m_terr   = 0;
  int m_cnt    = 0;

  always #5 clock = ~clock;

  hazard_stall_ctl #(
    .REG_ADDR_W(RW), .LOAD_BUBBLES(LB), .MEM_TIMEOUT(MT), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset),
    .id_src_a(id_src_a), .id_src_b(id_src_b),
    .id_uses_a(id_uses_a), .id_uses_b(id_uses_b),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_dst(ex_dst),
    .mem_multi(mem_multi), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_hold(id_ex_hold), .mem_freeze(mem_freeze),
    .timeout_err(timeout_err), .state(state), .stall_cycles(stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; id_src_a = '0; id_src_b = '0; id_uses_a = 1'b0; id_uses_b = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_dst = '0;
    mem_multi = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
  endtask

  // Check every output against the model mid-cycle, then advance both across an edge
  task automatic cyc();
    bit haz;
    bit e_pc, e_ifh, e_fl, e_st, e_exh, e_fz;
    @(negedge clock);
    #1;
    haz = ex_valid && ex_is_load && (ex_dst != 0) &&
          ((id_uses_a && id_src_a == ex_dst) || (id_uses_b && id_src_b == ex_dst));
    {e_pc, e_ifh, e_fl, e_st, e_exh, e_fz} = '0;
    if (reset) begin
      e_st = 1; e_fl = 1;
    end else if (m_mode == 0) begin
      if (branch_taken)   begin e_fl = 1; e_st = 1; end
      else if (mem_multi) begin e_pc = 1; e_ifh = 1; e_exh = 1; e_fz = 1; end
      else if (haz)       begin e_pc = 1; e_ifh = 1; e_st = 1; end
    end else if (m_mode == 1) begin
      if (branch_taken) begin e_fl = 1; e_st = 1; end
      else              begin e_pc = 1; e_ifh = 1; e_st = 1; end
    end else begin
      if (!mem_ready) begin e_pc = 1; e_ifh = 1; e_exh = 1; e_fz = 1; end
    end
    check("ctl", {26'd0, pc_hold, if_id_hold, if_id_flush, id_ex_stall, id_ex_hold, mem_freeze},
          {26'd0, e_pc, e_ifh, e_fl, e_st, e_exh, e_fz});
    check("state", 32'(state), 32'(m_mode));
    check("terr", 32'(timeout_err), 32'(m_terr));
    check("cnt", 32'(stall_cycles), 32'(m_cnt));
    @(posedge clock);
    if (reset) begin
      m_mode = 0; m_cnt = 0; m_terr = 0;
    end else begin
      if (e_pc && m_cnt < SAT) m_cnt++;
      case (m_mode)
        0: if (!branch_taken) begin
             if (mem_multi) begin m_mode = 2; m_waited = 0; end
             else if (haz && LB > 1) begin m_mode = 1; m_left = LB - 1; end
           end
        1: if (branch_taken) m_mode = 0;
           else begin m_left--; if (m_left == 0) m_mode = 0; end
        default: begin
          m_waited++;
          if (mem_ready) m_mode = 0;
          else if (m_waited == MT) begin m_mode = 0; m_terr = 1; end
        end
      endcase
    end
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    idle_inputs();
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_cnt", 32'(stall_cycles), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    cyc();
    reset = 1'b0;

    // Load-use on src_a: two bubbles
    ex_valid = 1; ex_is_load = 1; ex_dst = 5; id_uses_a = 1; id_src_a = 5;
    cyc();
    ex_valid = 0;
    cyc();
    cyc();
    check("lu_cnt", 32'(stall_cycles), 32'd2);
    check("lu_state", 32'(state), 32'd0);

    // Same shape via src_b, and the non-hazard variants
    do_reset();
    ex_valid = 1; ex_is_load = 1; ex_dst = 7; id_uses_b = 1; id_src_b = 7;
    cyc();
    ex_valid = 0;
    cyc();
    idle_inputs();
    ex_valid = 1; ex_is_load = 1; ex_dst = 0; id_uses_a = 1; id_src_a = 0;
    cyc();
    ex_dst = 5; id_src_a = 5; id_uses_a = 0;
    cyc();
    check("nohaz_cnt", 32'(stall_cycles), 32'd2);

    // Multi-cycle access: ready seen on the fifth MEM_WAIT cycle
    do_reset();
    mem_multi = 1; mem_ready = 1;
    cyc();
    mem_multi = 0; mem_ready = 0;
    repeat (4) cyc();
    mem_ready = 1;
    cyc();
    mem_ready = 0;
    cyc();
    check("mw_cnt", 32'(stall_cycles), 32'd5);
    check("mw_terr", 32'(timeout_err), 32'd0);

    // Timeout: ready never arrives, branch pulses ignored while frozen
    do_reset();
    mem_multi = 1;
    cyc();
    mem_multi = 0;
    n = 0;
    while (state == 2'd2 && n < 40) begin
      branch_taken = (n == 3);
      cyc();
      n++;
    end
    branch_taken = 0;
    check("to_len", 32'(n), 32'(MT));
    repeat (3) cyc();
    check("to_sticky", 32'(timeout_err), 32'd1);

    // Branch beats a simultaneous hazard; branch during a load stall
    do_reset();
    ex_valid = 1; ex_is_load = 1; ex_dst = 3; id_uses_a = 1; id_src_a = 3; branch_taken = 1;
    cyc();
    check("br_hold", 32'(pc_hold), 32'd0);
    branch_taken = 0;
    cyc();
    branch_taken = 1;
    cyc();
    idle_inputs();
    cyc();

    // Reset in the third MEM_WAIT cycle
    mem_multi = 1;
    cyc();
    mem_multi = 0;
    cyc();
    cyc();
    reset = 1;
    cyc();
    reset = 0;
    check("rmw_state", 32'(state), 32'd0);
    check("rmw_cnt", 32'(stall_cycles), 32'd0);
    cyc();

    // Randomized traffic over a small register range to provoke hazards
    for (int i = 0; i < 4000; i++) begin
      bit slow = ((i / 500) % 2) == 1;
      reset        = ($urandom_range(0, 99) < 2);
      ex_valid     = ($urandom_range(0, 9) < 8);
      ex_is_load   = ($urandom_range(0, 9) < 6);
      ex_dst       = RW'($urandom_range(0, 3));
      id_src_a     = RW'($urandom_range(0, 3));
      id_src_b     = RW'($urandom_range(0, 3));
      id_uses_a    = $urandom_range(0, 1);
      id_uses_b    = $urandom_range(0, 1);
      mem_multi    = ($urandom_range(0, 9) < 1);
      mem_ready    = slow ? ($urandom_range(0, 99) < 3) : ($urandom_range(0, 9) < 3);
      branch_taken = ($urandom_range(0, 9) < 1);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
